// File: rtl/hpi_bus_sequencer_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
package hpi_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RECOVER  = 3'd5
    } hpi_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } hpi_req_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // Used to size the shared phase counter from the largest timing count.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hpi_bus_sequencer_if.sv
// Requester handshakes, completion response and HPI pad signals.
// master = requester/pad side, slave = the sequencer.
interface hpi_bus_sequencer_if;

    logic        req0_valid;
    logic        req0_ready;
    logic        req0_we;
    logic [1:0]  req0_addr;
    logic [15:0] req0_wdata;

    logic        req1_valid;
    logic        req1_ready;
    logic        req1_we;
    logic [1:0]  req1_addr;
    logic [15:0] req1_wdata;

    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_rdata;
    logic        busy;

    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic        hpi_reset_n;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output hpi_data_in,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_rdata, busy,
        input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
        input  hpi_data_out, hpi_data_oe
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  hpi_data_in,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_rdata, busy,
        output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n,
        output hpi_data_out, hpi_data_oe
    );

endinterface

// File: rtl/hpi_bus_sequencer_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module hpi_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot grant, nothing granted while the sequencer is not idle.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i[0] && (!valid_i[1] || last_grant_i)) begin
                grant_o = 2'b01;
            end else if (valid_i[1]) begin
                grant_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/hpi_bus_sequencer.sv
// HPI bus sequencer: chip reset pulse, request arbitration and timed
// setup/strobe/hold/recover bus cycles with a one-cycle response strobe.
//
// state      | meaning
// RST_HOLD   | hpi_reset_n low for RST_CYC cycles
// IDLE       | arbitrating, winner sees ready
// SETUP      | cs_n low, address/write data valid
// STROBE     | r_n or w_n low, read data captured on last cycle
// HOLD       | strobes released, rsp_valid on first cycle
// RECOVER    | cs_n high before next access
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned RST_CYC     = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    hpi_bus_sequencer_if.slave bus
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, STROBE_CYC),
                                                  max_u(HOLD_CYC, RECOVER_CYC)), RST_CYC);
    localparam int unsigned CW = $clog2(MAX_CYC + 1);

    typedef logic [CW-1:0] cnt_t;

    // Counter is loaded with count-1 on entry and the state exits at zero.
    localparam cnt_t LD_SETUP   = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t LD_STROBE  = cnt_t'(STROBE_CYC - 1);
    localparam cnt_t LD_HOLD    = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t LD_RECOVER = cnt_t'(RECOVER_CYC - 1);
    localparam cnt_t LD_RST     = cnt_t'(RST_CYC - 1);

    hpi_state_t  state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    hpi_req_t    req_q, req_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] rdata_q, rdata_d;

    logic [1:0]  valid;
    logic [1:0]  grant;
    logic        cnt_zero;

    logic        cs_n, r_n, w_n, oe, chip_rst_n, rsp_valid;

    assign valid    = {bus.req1_valid, bus.req0_valid};
    assign cnt_zero = (cnt_q == '0);

    hpi_rr_arbiter u_arb (
        .valid_i      (valid),
        .enable_i     (state_q == ST_IDLE),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // State, phase counter and latched request registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= ST_RST_HOLD;
            cnt_q        <= LD_RST;
            req_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state, counter load/decrement and request latching.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            ST_RST_HOLD: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_d   = cnt_q - cnt_t'(1);
            end
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d      = ST_SETUP;
                    cnt_d        = LD_SETUP;
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    rdata_d      = '0;
                    if (grant[1]) req_d = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata};
                    else          req_d = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata};
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                    if (!req_q.we) rdata_d = bus.hpi_data_in;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_RECOVER;
                    cnt_d   = LD_RECOVER;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_d   = cnt_q - cnt_t'(1);
            end
            default: begin
                state_d = ST_RST_HOLD;
                cnt_d   = LD_RST;
            end
        endcase
    end

    // Pad strobes and response decoded from the current state.
    always_comb begin
        cs_n       = 1'b1;
        r_n        = 1'b1;
        w_n        = 1'b1;
        oe         = 1'b0;
        chip_rst_n = 1'b1;
        rsp_valid  = 1'b0;
        unique case (state_q)
            ST_RST_HOLD: chip_rst_n = 1'b0;
            ST_SETUP: begin
                cs_n = 1'b0;
                oe   = req_q.we;
            end
            ST_STROBE: begin
                cs_n = 1'b0;
                oe   = req_q.we;
                r_n  = req_q.we;
                w_n  = !req_q.we;
            end
            ST_HOLD: begin
                cs_n      = 1'b0;
                oe        = req_q.we;
                rsp_valid = (cnt_q == LD_HOLD);
            end
            default: ;
        endcase
    end

    assign bus.req0_ready   = grant[0];
    assign bus.req1_ready   = grant[1];
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.hpi_addr     = req_q.addr;
    assign bus.hpi_cs_n     = cs_n;
    assign bus.hpi_r_n      = r_n;
    assign bus.hpi_w_n      = w_n;
    assign bus.hpi_reset_n  = chip_rst_n;
    assign bus.hpi_data_oe  = oe;
    assign bus.hpi_data_out = oe ? req_q.wdata : 16'h0000;

endmodule
